// File: rtl/periph_xbar_ooo_guard.sv
// Peripheral crossbar: N_MASTER ports to N_SLAVE targets plus a built-in error target.
// Per-slave round-robin arbitration, multiple outstanding per master, same-target ordering guard.
module periph_xbar_ooo_guard #(
    parameter int unsigned N_MASTER        = 4,
    parameter int unsigned N_SLAVE         = 3,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned SEL_LSB         = 10,
    parameter int unsigned SEL_MSB         = 11,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0][5:0]             data_atop_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic [N_MASTER-1:0]                  data_r_valid_o,
    output logic [N_MASTER-1:0]                  data_r_opc_o,
    output logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_r_rdata_o,
    output logic [N_SLAVE-1:0]                   data_req_o,
    output logic [N_SLAVE-1:0]                   data_wen_o,
    output logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]   data_add_o,
    output logic [N_SLAVE-1:0][5:0]              data_atop_o,
    output logic [N_SLAVE-1:0][DATA_WIDTH-1:0]   data_wdata_o,
    output logic [N_SLAVE-1:0][BE_WIDTH-1:0]     data_be_o,
    output logic [N_SLAVE-1:0][N_MASTER-1:0]     data_ID_o,
    input  logic [N_SLAVE-1:0]                   data_gnt_i,
    input  logic [N_SLAVE-1:0]                   data_r_valid_i,
    input  logic [N_SLAVE-1:0]                   data_r_opc_i,
    input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]   data_r_rdata_i,
    input  logic [N_SLAVE-1:0][N_MASTER-1:0]     data_r_ID_i
);

    localparam int unsigned TW = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    logic [N_MASTER-1:0][TW-1:0] tgt;
    logic [N_MASTER-1:0]         is_err;
    logic [N_MASTER-1:0]         elig;
    logic [N_MASTER-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_MASTER-1:0][TW-1:0] last_q, last_d;
    logic [N_SLAVE-1:0][PW-1:0]  ptr_q, ptr_d;
    logic [N_MASTER-1:0]         err_v_q, err_v_d;
    logic [N_SLAVE-1:0][PW-1:0]  win;
    logic [N_SLAVE-1:0]          win_v;
    logic [N_MASTER-1:0]         gnt;
    logic [N_MASTER-1:0]         hit;

    // Decode and eligibility; rst_n gating keeps every output at 0 during reset.
    always_comb begin
        tgt    = '0;
        is_err = '0;
        elig   = '0;
        for (int k = 0; k < int'(N_MASTER); k++) begin
            tgt[k]    = data_add_i[k][SEL_MSB:SEL_LSB];
            is_err[k] = (32'(tgt[k]) >= N_SLAVE);
            elig[k]   = rst_n && data_req_i[k]
                        && (cnt_q[k] < CW'(MAX_OUTSTANDING))
                        && ((cnt_q[k] == '0) || (tgt[k] == last_q[k]));
        end
    end

    // Round-robin winner search starting at ptr, wrapping modulo N_MASTER.
    always_comb begin
        win_v = '0;
        win   = '0;
        for (int j = 0; j < int'(N_SLAVE); j++) begin
            for (int off = 0; off < int'(N_MASTER); off++) begin
                logic [PW-1:0] ci;
                ci = PW'((32'(ptr_q[j]) + 32'(off)) % N_MASTER);
                if (!win_v[j] && elig[ci] && !is_err[ci] && (32'(tgt[ci]) == 32'(j))) begin
                    win_v[j] = 1'b1;
                    win[j]   = ci;
                end
            end
        end
    end

    // Slave-side request mux, pointer advance and master grants.
    always_comb begin
        data_req_o   = '0;
        data_wen_o   = '0;
        data_add_o   = '0;
        data_atop_o  = '0;
        data_wdata_o = '0;
        data_be_o    = '0;
        data_ID_o    = '0;
        ptr_d        = ptr_q;
        gnt          = elig & is_err;
        for (int j = 0; j < int'(N_SLAVE); j++) begin
            if (win_v[j]) begin
                data_req_o[j]   = 1'b1;
                data_wen_o[j]   = data_wen_i[win[j]];
                data_add_o[j]   = data_add_i[win[j]];
                data_atop_o[j]  = data_atop_i[win[j]];
                data_wdata_o[j] = data_wdata_i[win[j]];
                data_be_o[j]    = data_be_i[win[j]];
                data_ID_o[j]    = N_MASTER'(1) << win[j];
                if (data_gnt_i[j]) begin
                    gnt[win[j]] = 1'b1;
                    ptr_d[j]    = PW'((32'(win[j]) + 32'd1) % N_MASTER);
                end
            end
        end
        data_gnt_o = gnt;
    end

    // Response routing: lowest slave index first, error slot last.
    always_comb begin
        hit            = '0;
        data_r_valid_o = '0;
        data_r_opc_o   = '0;
        data_r_rdata_o = '0;
        for (int k = 0; k < int'(N_MASTER); k++) begin
            for (int j = 0; j < int'(N_SLAVE); j++) begin
                if (!hit[k] && data_r_valid_i[j] && data_r_ID_i[j][k]) begin
                    hit[k]            = 1'b1;
                    data_r_opc_o[k]   = data_r_opc_i[j];
                    data_r_rdata_o[k] = data_r_rdata_i[j];
                end
            end
            if (!hit[k] && err_v_q[k]) begin
                hit[k]          = 1'b1;
                data_r_opc_o[k] = 1'b1;
            end
            if (!rst_n) begin
                hit[k]            = 1'b0;
                data_r_opc_o[k]   = 1'b0;
                data_r_rdata_o[k] = '0;
            end
            data_r_valid_o[k] = hit[k];
        end
    end

    // Outstanding counters; a response with nothing outstanding is not counted.
    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_v_d = gnt & is_err;
        for (int k = 0; k < int'(N_MASTER); k++) begin
            if (gnt[k]) begin
                last_d[k] = tgt[k];
            end
            if (gnt[k] && !(hit[k] && (cnt_q[k] != '0))) begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end else if (!gnt[k] && hit[k] && (cnt_q[k] != '0)) begin
                cnt_d[k] = cnt_q[k] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            last_q  <= '0;
            ptr_q   <= '0;
            err_v_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
            err_v_q <= err_v_d;
        end
    end

endmodule

// File: tb/tb_periph_xbar_ooo_guard.sv
// Directed bench for periph_xbar_ooo_guard: decode, arbitration, ordering guard, limits, reset.
module tb_periph_xbar_ooo_guard;

    localparam int NM = 4;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic                   clk;
    logic                   rst_n;
    logic [NM-1:0]          data_req_i;
    logic [NM-1:0]          data_wen_i;
    logic [NM-1:0][AW-1:0]  data_add_i;
    logic [NM-1:0][5:0]     data_atop_i;
    logic [NM-1:0][DW-1:0]  data_wdata_i;
    logic [NM-1:0][BW-1:0]  data_be_i;
    logic [NM-1:0]          data_gnt_o;
    logic [NM-1:0]          data_r_valid_o;
    logic [NM-1:0]          data_r_opc_o;
    logic [NM-1:0][DW-1:0]  data_r_rdata_o;
    logic [NS-1:0]          data_req_o;
    logic [NS-1:0]          data_wen_o;
    logic [NS-1:0][AW-1:0]  data_add_o;
    logic [NS-1:0][5:0]     data_atop_o;
    logic [NS-1:0][DW-1:0]  data_wdata_o;
    logic [NS-1:0][BW-1:0]  data_be_o;
    logic [NS-1:0][NM-1:0]  data_ID_o;
    logic [NS-1:0]          data_gnt_i;
    logic [NS-1:0]          data_r_valid_i;
    logic [NS-1:0]          data_r_opc_i;
    logic [NS-1:0][DW-1:0]  data_r_rdata_i;
    logic [NS-1:0][NM-1:0]  data_r_ID_i;

    int checks = 0;
    int errors = 0;

    periph_xbar_ooo_guard dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_wen_i(data_wen_i), .data_add_i(data_add_i),
        .data_atop_i(data_atop_i), .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
        .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o), .data_r_opc_o(data_r_opc_o),
        .data_r_rdata_o(data_r_rdata_o),
        .data_req_o(data_req_o), .data_wen_o(data_wen_o), .data_add_o(data_add_o),
        .data_atop_o(data_atop_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
        .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
        .data_r_opc_i(data_r_opc_i), .data_r_rdata_i(data_r_rdata_i), .data_r_ID_i(data_r_ID_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        data_req_i = '0; data_wen_i = '0; data_add_i = '0; data_atop_i = '0;
        data_wdata_i = '0; data_be_i = '0; data_gnt_i = '0; data_r_valid_i = '0;
        data_r_opc_i = '0; data_r_rdata_i = '0; data_r_ID_i = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge, reset released, inputs idle.
    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        data_req_i = 4'hF;
        data_wen_i = 4'hF;
        data_be_i[0] = 4'hF;
        data_gnt_i = 3'b111;
        data_r_valid_i = 3'b001;
        data_r_ID_i[0] = 4'b0001;
        data_r_rdata_i[0] = 32'hDEAD_BEEF;
        #1;
        checks++; if (data_gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", data_gnt_o); end
        checks++; if (data_req_o !== 3'b000) begin errors++; $display("FAIL reset_req got %b exp 000", data_req_o); end
        checks++; if (data_r_valid_o !== 4'b0000 || data_r_rdata_o !== '0) begin errors++; $display("FAIL reset_rvalid got %b exp 0000", data_r_valid_o); end
        checks++; if (data_ID_o !== '0 || data_be_o !== '0 || data_wen_o !== '0) begin errors++; $display("FAIL reset_fields got id %h be %h exp 0", data_ID_o, data_be_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_unmapped();
        reset_dut();
        data_req_i[0] = 1'b1; data_wen_i[0] = 1'b1; data_add_i[0] = 32'h0000_0C00;
        #1;
        checks++; if (data_gnt_o !== 4'b0001) begin errors++; $display("FAIL unmapped_gnt got %b exp 0001", data_gnt_o); end
        checks++; if (data_req_o !== 3'b000) begin errors++; $display("FAIL unmapped_req got %b exp 000", data_req_o); end
        @(posedge clk); #1;
        data_req_i = '0;
        #1;
        checks++; if (data_r_valid_o !== 4'b0001) begin errors++; $display("FAIL unmapped_rvalid got %b exp 0001", data_r_valid_o); end
        checks++; if (data_r_opc_o !== 4'b0001) begin errors++; $display("FAIL unmapped_opc got %b exp 0001", data_r_opc_o); end
        checks++; if (data_r_rdata_o[0] !== 32'h0) begin errors++; $display("FAIL unmapped_rdata got %h exp 0", data_r_rdata_o[0]); end
        @(posedge clk); #1;
        checks++; if (data_r_valid_o !== 4'b0000) begin errors++; $display("FAIL unmapped_rvalid_end got %b exp 0000", data_r_valid_o); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        data_req_i[0] = 1'b1; data_add_i[0] = 32'h0000_0C04;
        #1;
        checks++; if (data_gnt_o !== 4'b0001) begin errors++; $display("FAIL b2b_gnt0 got %b exp 0001", data_gnt_o); end
        @(posedge clk); #1;
        checks++; if (data_gnt_o !== 4'b0001) begin errors++; $display("FAIL b2b_gnt1 got %b exp 0001", data_gnt_o); end
        checks++; if (data_r_valid_o !== 4'b0001) begin errors++; $display("FAIL b2b_rv1 got %b exp 0001", data_r_valid_o); end
        @(posedge clk); #1;
        data_req_i = '0;
        #1;
        checks++; if (data_r_valid_o !== 4'b0001) begin errors++; $display("FAIL b2b_rv2 got %b exp 0001", data_r_valid_o); end
        @(posedge clk); #1;
        checks++; if (data_r_valid_o !== 4'b0000) begin errors++; $display("FAIL b2b_rv3 got %b exp 0000", data_r_valid_o); end
        // counter must be back to zero so a different target is accepted
        data_req_i[0] = 1'b1; data_add_i[0] = 32'h0000_0400; data_gnt_i = 3'b010;
        #1;
        checks++; if (data_gnt_o !== 4'b0001) begin errors++; $display("FAIL b2b_drain got %b exp 0001", data_gnt_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        reset_dut();
        data_req_i = 4'hF;
        for (int k = 0; k < NM; k++) begin
            data_add_i[k]   = 32'h0000_0400 + 32'(4 * k);
            data_wdata_i[k] = 32'h0000_00A0 + 32'(k);
        end
        data_gnt_i = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp = 4'b0001 << (i % 4);
            checks++; if (data_gnt_o !== exp) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", i, data_gnt_o, exp); end
            checks++; if (data_ID_o[1] !== exp) begin errors++; $display("FAIL rr_id%0d got %b exp %b", i, data_ID_o[1], exp); end
            checks++; if (data_add_o[1] !== 32'h0000_0400 + 32'(4 * (i % 4)) || data_wdata_o[1] !== 32'h0000_00A0 + 32'(i % 4)) begin
                errors++; $display("FAIL rr_fields%0d got add %h wdata %h", i, data_add_o[1], data_wdata_o[1]);
            end
            checks++; if (data_req_o !== 3'b010) begin errors++; $display("FAIL rr_req%0d got %b exp 010", i, data_req_o); end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_ordering();
        reset_dut();
        data_req_i[2] = 1'b1; data_add_i[2] = 32'h0000_0000; data_gnt_i = 3'b101;
        #1;
        checks++; if (data_gnt_o !== 4'b0100) begin errors++; $display("FAIL ord_first got %b exp 0100", data_gnt_o); end
        @(posedge clk); #1;
        data_add_i[2] = 32'h0000_0800;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (data_gnt_o !== 4'b0000 || data_req_o !== 3'b000) begin
                errors++; $display("FAIL ord_block%0d got gnt %b req %b exp 0000 000", i, data_gnt_o, data_req_o);
            end
            @(posedge clk); #1;
        end
        data_r_valid_i[0] = 1'b1; data_r_ID_i[0] = 4'b0100; data_r_rdata_i[0] = 32'h1234_5678;
        #1;
        checks++; if (data_r_valid_o !== 4'b0100) begin errors++; $display("FAIL ord_rvalid got %b exp 0100", data_r_valid_o); end
        checks++; if (data_r_rdata_o[2] !== 32'h1234_5678 || data_r_opc_o !== 4'b0000) begin
            errors++; $display("FAIL ord_rdata got %h opc %b exp 12345678 0000", data_r_rdata_o[2], data_r_opc_o);
        end
        checks++; if (data_gnt_o !== 4'b0000) begin errors++; $display("FAIL ord_still_blocked got %b exp 0000", data_gnt_o); end
        @(posedge clk); #1;
        data_r_valid_i = '0; data_r_ID_i = '0; data_r_rdata_i = '0;
        #1;
        checks++; if (data_req_o !== 3'b100 || data_ID_o[2] !== 4'b0100) begin
            errors++; $display("FAIL ord_release got req %b id %b exp 100 0100", data_req_o, data_ID_o[2]);
        end
        checks++; if (data_gnt_o !== 4'b0100) begin errors++; $display("FAIL ord_release_gnt got %b exp 0100", data_gnt_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_outstanding();
        reset_dut();
        data_req_i[1] = 1'b1; data_add_i[1] = 32'h0000_0010; data_gnt_i = 3'b001;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (data_gnt_o !== 4'b0010) begin errors++; $display("FAIL lim_gnt%0d got %b exp 0010", i, data_gnt_o); end
            @(posedge clk); #1;
        end
        #1;
        checks++; if (data_gnt_o !== 4'b0000 || data_req_o !== 3'b000) begin
            errors++; $display("FAIL lim_held got gnt %b req %b exp 0000 000", data_gnt_o, data_req_o);
        end
        @(posedge clk); #1;
        data_r_valid_i[0] = 1'b1; data_r_ID_i[0] = 4'b0010;
        #1;
        checks++; if (data_gnt_o !== 4'b0000 || data_r_valid_o !== 4'b0010) begin
            errors++; $display("FAIL lim_resp got gnt %b rvalid %b exp 0000 0010", data_gnt_o, data_r_valid_o);
        end
        @(posedge clk); #1;
        data_r_valid_i = '0; data_r_ID_i = '0;
        #1;
        checks++; if (data_gnt_o !== 4'b0010) begin errors++; $display("FAIL lim_fifth got %b exp 0010", data_gnt_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_stall_reset();
        reset_dut();
        data_req_i[3] = 1'b1; data_add_i[3] = 32'h0000_0800; data_gnt_i = 3'b100;
        #1;
        checks++; if (data_gnt_o !== 4'b1000) begin errors++; $display("FAIL stall_pre got %b exp 1000", data_gnt_o); end
        @(posedge clk); #1;
        data_req_i = 4'b0011; data_gnt_i = '0;
        data_add_i[0] = 32'h0000_0020; data_wdata_i[0] = 32'hCAFE_0000; data_be_i[0] = 4'hF; data_atop_i[0] = 6'h21;
        data_add_i[1] = 32'h0000_0024; data_wdata_i[1] = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (data_req_o !== 3'b001 || data_ID_o[0] !== 4'b0001 || data_add_o[0] !== 32'h0000_0020) begin
                errors++; $display("FAIL stall_hold%0d got req %b id %b add %h", i, data_req_o, data_ID_o[0], data_add_o[0]);
            end
            checks++; if (data_gnt_o !== 4'b0000) begin errors++; $display("FAIL stall_gnt%0d got %b exp 0000", i, data_gnt_o); end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (data_gnt_o !== '0 || data_req_o !== '0 || data_add_o !== '0 || data_ID_o !== '0) begin
            errors++; $display("FAIL stall_rst_a got gnt %b req %b add %h id %h", data_gnt_o, data_req_o, data_add_o, data_ID_o);
        end
        checks++; if (data_wdata_o !== '0 || data_be_o !== '0 || data_atop_o !== '0 || data_r_valid_o !== '0) begin
            errors++; $display("FAIL stall_rst_b got wdata %h be %h atop %h rv %b", data_wdata_o, data_be_o, data_atop_o, data_r_valid_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
        data_r_valid_i[2] = 1'b1; data_r_ID_i[2] = 4'b1000; data_r_rdata_i[2] = 32'h0BAD_F00D;
        #1;
        checks++; if (data_r_valid_o !== 4'b1000 || data_r_rdata_o[3] !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL stale_resp got rv %b rdata %h exp 1000 0badf00d", data_r_valid_o, data_r_rdata_o[3]);
        end
        @(posedge clk); #1;
        clear_inputs();
        data_req_i[3] = 1'b1; data_add_i[3] = 32'h0000_0000; data_gnt_i = 3'b001;
        #1;
        checks++; if (data_gnt_o !== 4'b1000) begin errors++; $display("FAIL post_rst_cnt got %b exp 1000", data_gnt_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_unmapped();
        test_back_to_back();
        test_round_robin();
        test_ordering();
        test_outstanding();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
